// File: rtl/risc16_ctrl.sv
// risc16_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/HALT sequencer driving the RiSC-16 datapath.
// Define RISC16_CTRL_PERF_EN to add the retire_cnt / stall_cnt performance counters.
module risc16_ctrl #(
  parameter logic [15:0] HALT_WORD = 16'hE071
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic [15:0] ir,
  output logic [2:0]  rf_ra1,
  output logic [2:0]  rf_ra2,
  output logic [2:0]  rf_wa,
  output logic        rf_we,
  output logic [1:0]  rf_wsel,
  output logic        src1_sel,
  output logic        src2_sel,
  output logic        ADD,
  output logic        NAND,
  output logic        PASS1,
  output logic        EQ,
  input  logic        eq_out,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        retire,
  output logic        halted
`ifdef RISC16_CTRL_PERF_EN
  ,
  output logic [31:0] retire_cnt,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT} state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_LUI  = 3'b011;
  localparam logic [2:0] OP_SW   = 3'b100;
  localparam logic [2:0] OP_LW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_JALR = 3'b111;

  // ld_we / mem_pc_we are armed in MEM and only take effect on mem_ready;
  // beq makes pc_sel follow eq_out instead of the registered value.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic [2:0] ra1;
    logic [2:0] ra2;
    logic [2:0] wa;
    logic       rf_we;
    logic       ld_we;
    logic [1:0] wsel;
    logic       src1_sel;
    logic       src2_sel;
    logic       add;
    logic       nand_op;
    logic       pass1;
    logic       eq;
    logic       pc_we;
    logic       mem_pc_we;
    logic [1:0] pc_sel;
    logic       beq;
    logic       halted;
  } ctl_t;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  ctl_t        ctl_q;

  function automatic ctl_t decode(input state_t s, input logic [15:0] i);
    ctl_t       c;
    logic [2:0] op, ra, rb, rc;
    op = i[15:13];
    ra = i[12:10];
    rb = i[9:7];
    rc = i[2:0];
    c  = '0;
    case (s)
      S_FETCH: c.mem_req = 1'b1;
      S_HALT:  c.halted  = 1'b1;
      default: begin
        case (op)
          OP_ADD, OP_NAND:  begin c.ra1 = rb; c.ra2 = rc; end
          OP_ADDI, OP_JALR: c.ra1 = rb;
          OP_SW, OP_LW:     begin c.ra1 = rb; c.ra2 = ra; end
          OP_BEQ:           begin c.ra1 = ra; c.ra2 = rb; end
          default: ;
        endcase
        c.wa = ra;
        if (s == S_EXEC) begin
          c.add      = op inside {OP_ADD, OP_ADDI, OP_SW, OP_LW};
          c.nand_op  = (op == OP_NAND);
          c.pass1    = op inside {OP_LUI, OP_JALR};
          c.eq       = (op == OP_BEQ);
          c.src1_sel = (op == OP_LUI);
          c.src2_sel = op inside {OP_ADDI, OP_SW, OP_LW};
          if (i != HALT_WORD && !(op inside {OP_SW, OP_LW})) begin
            c.pc_we  = 1'b1;
            c.beq    = (op == OP_BEQ);
            c.pc_sel = (op == OP_JALR) ? 2'b10 : 2'b00;
            c.rf_we  = (op != OP_BEQ) && (ra != 3'd0);
            c.wsel   = (op == OP_JALR) ? 2'b10 : 2'b00;
          end
        end else if (s == S_MEM) begin
          c.add          = 1'b1;
          c.src2_sel     = 1'b1;
          c.mem_req      = 1'b1;
          c.mem_addr_sel = 1'b1;
          c.mem_we       = (op == OP_SW);
          c.mem_pc_we    = 1'b1;
          c.ld_we        = (op == OP_LW) && (ra != 3'd0);
          c.wsel         = (op == OP_LW) ? 2'b01 : 2'b00;
        end
      end
    endcase
    return c;
  endfunction

  // Handshakes are qualified by the registered request so a stray mem_ready is ignored.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      S_FETCH:  if (ctl_q.mem_req && mem_ready) begin
                  ir_d    = mem_rdata;
                  state_d = S_DECODE;
                end
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   if (ir_q == HALT_WORD)                       state_d = S_HALT;
                else if (ir_q[15:13] inside {OP_SW, OP_LW})  state_d = S_MEM;
                else                                         state_d = S_FETCH;
      S_MEM:    if (ctl_q.mem_req && mem_ready) state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      ctl_q   <= decode(state_d, ir_d);
    end
  end

  assign mem_req      = ctl_q.mem_req;
  assign mem_we       = ctl_q.mem_we;
  assign mem_addr_sel = ctl_q.mem_addr_sel;
  assign ir           = ir_q;
  assign rf_ra1       = ctl_q.ra1;
  assign rf_ra2       = ctl_q.ra2;
  assign rf_wa        = ctl_q.wa;
  assign rf_we        = ctl_q.rf_we | (ctl_q.ld_we & mem_ready);
  assign rf_wsel      = ctl_q.wsel;
  assign src1_sel     = ctl_q.src1_sel;
  assign src2_sel     = ctl_q.src2_sel;
  assign ADD          = ctl_q.add;
  assign NAND         = ctl_q.nand_op;
  assign PASS1        = ctl_q.pass1;
  assign EQ           = ctl_q.eq;
  assign pc_we        = ctl_q.pc_we | (ctl_q.mem_pc_we & mem_ready);
  assign pc_sel       = ctl_q.beq ? {1'b0, eq_out} : ctl_q.pc_sel;
  assign retire       = pc_we;
  assign halted       = ctl_q.halted;

`ifdef RISC16_CTRL_PERF_EN
  logic [31:0] retire_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retire_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else if (state_q != S_HALT) begin
      if (retire)                 retire_cnt_q <= retire_cnt_q + 32'd1;
      if (mem_req && !mem_ready)  stall_cnt_q  <= stall_cnt_q + 32'd1;
    end
  end

  assign retire_cnt = retire_cnt_q;
  assign stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_risc16_ctrl.sv
// Randomized bench for risc16_ctrl: per-cycle outputs checked against an opcode-table model.
module tb_risc16_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [15:0] HALT = 16'hE071;

  logic        rst_n, mem_ready, eq_out;
  logic [15:0] mem_rdata, ir;
  logic        mem_req, mem_we, mem_addr_sel, rf_we, src1_sel, src2_sel;
  logic        ADD, NAND, PASS1, EQ, pc_we, retire, halted;
  logic [2:0]  rf_ra1, rf_ra2, rf_wa;
  logic [1:0]  rf_wsel, pc_sel;
`ifdef RISC16_CTRL_PERF_EN
  logic [31:0] retire_cnt, stall_cnt;
`endif

  risc16_ctrl #(.HALT_WORD(HALT)) dut (
    .clk(clk), .rst_n(rst_n), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir(ir),
    .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_wa(rf_wa), .rf_we(rf_we), .rf_wsel(rf_wsel),
    .src1_sel(src1_sel), .src2_sel(src2_sel), .ADD(ADD), .NAND(NAND), .PASS1(PASS1),
    .EQ(EQ), .eq_out(eq_out), .pc_we(pc_we), .pc_sel(pc_sel), .retire(retire),
    .halted(halted)
`ifdef RISC16_CTRL_PERF_EN
    , .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
`endif
  );

  typedef enum int {P_FETCH, P_DEC, P_EXEC, P_MEM, P_HALT} phase_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic [2:0] ra1;
    logic [2:0] ra2;
    logic [2:0] wa;
    logic       rf_we;
    logic [1:0] wsel;
    logic       src1;
    logic       src2;
    logic       add;
    logic       nnd;
    logic       pass1;
    logic       eq;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       retire;
    logic       halted;
  } o_t;

  o_t got;
  assign got = {mem_req, mem_we, mem_addr_sel, rf_ra1, rf_ra2, rf_wa, rf_we, rf_wsel,
                src1_sel, src2_sel, ADD, NAND, PASS1, EQ, pc_we, pc_sel, retire, halted};

  int n_tests = 0;
  int n_fail  = 0;
  int exp_ret = 0;
  int exp_stall = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected outputs for one cycle; mask bit 0 marks a field the rules leave free.
  function automatic void model(input phase_t ph, input logic [15:0] i, input bit eqv,
                                input bit rdy, output o_t e, output o_t m);
    logic [2:0] op, a, b, c;
    bit halt, memop, wr;
    op = i[15:13]; a = i[12:10]; b = i[9:7]; c = i[2:0];
    halt  = (i == HALT);
    memop = (op == 3'd4) || (op == 3'd5);
    wr    = !halt && !memop && (op != 3'd6);
    e = '0;
    m = '1;
    if (ph == P_FETCH || ph == P_HALT) begin
      m.ra1 = '0; m.ra2 = '0; m.wa = '0;
      e.mem_req = (ph == P_FETCH);
      e.halted  = (ph == P_HALT);
      return;
    end
    case (op)
      3'd0, 3'd2: begin e.ra1 = b; e.ra2 = c; end
      3'd1, 3'd7: begin e.ra1 = b; m.ra2 = '0; end
      3'd3:       begin m.ra1 = '0; m.ra2 = '0; end
      3'd4, 3'd5: begin e.ra1 = b; e.ra2 = a; end
      default:    begin e.ra1 = a; e.ra2 = b; end
    endcase
    m.wa = '0; m.wsel = '0; m.pc_sel = '0;
    if (ph == P_DEC) begin
      m.src1 = 1'b0; m.src2 = 1'b0;
    end else if (ph == P_EXEC) begin
      if (halt) begin
        m.ra1 = '0; m.ra2 = '0; m.src1 = 1'b0; m.src2 = 1'b0;
        m.add = 1'b0; m.nnd = 1'b0; m.pass1 = 1'b0; m.eq = 1'b0;
      end else begin
        e.add   = op inside {3'd0, 3'd1, 3'd4, 3'd5};
        e.nnd   = (op == 3'd2);
        e.pass1 = op inside {3'd3, 3'd7};
        e.eq    = (op == 3'd6);
        e.src1  = (op == 3'd3);
        e.src2  = op inside {3'd1, 3'd4, 3'd5};
        if (!memop) begin
          e.pc_we = 1'b1; e.retire = 1'b1; m.pc_sel = '1;
          e.pc_sel = (op == 3'd6) ? {1'b0, eqv} : (op == 3'd7) ? 2'b10 : 2'b00;
        end
        if (wr) begin
          e.rf_we = (a != 3'd0); e.wa = a; m.wa = '1; m.wsel = '1;
          e.wsel = (op == 3'd7) ? 2'b10 : 2'b00;
        end
      end
    end else begin
      e.add = 1'b1; e.src2 = 1'b1; e.mem_req = 1'b1; e.mem_addr_sel = 1'b1;
      e.mem_we = (op == 3'd4);
      if (rdy) begin e.pc_we = 1'b1; e.retire = 1'b1; m.pc_sel = '1; end
      if (op == 3'd5) begin
        e.rf_we = rdy && (a != 3'd0); e.wa = a; m.wa = '1; m.wsel = '1; e.wsel = 2'b01;
      end
    end
  endfunction

  task automatic step(input bit rdy, input bit eqv, input logic [15:0] rd);
    @(posedge clk);
    #1 mem_ready = rdy; eq_out = eqv; mem_rdata = rd;
    #1;
  endtask

  task automatic cmp(input string tag, input phase_t ph, input logic [15:0] i,
                     input bit eqv, input bit rdy);
    o_t e, m;
    model(ph, i, eqv, rdy, e, m);
    if (e.retire) exp_ret++;
    if (e.mem_req && !rdy) exp_stall++;
    check($sformatf("%s_%h", tag, i), 32'(got & m), 32'(e & m));
  endtask

  task automatic check_perf(input string tag);
`ifdef RISC16_CTRL_PERF_EN
    check({tag, "_retire_cnt"}, retire_cnt, exp_ret);
    check({tag, "_stall_cnt"}, stall_cnt, exp_stall);
`else
    if (tag.len() == 0) $display("[TB] empty perf tag");
`endif
  endtask

  task automatic run_instr(input logic [15:0] instr, input int fs, input int ms, input bit eqv);
    int cyc, ret_cyc;
    bit memop, r;
    cyc = 0; ret_cyc = -1;
    memop = (instr[15:14] == 2'b10);
    for (int k = 0; k <= fs; k++) begin
      step(k == fs, eqv, (k == fs) ? instr : 16'($urandom));
      cyc++;
      cmp("fetch", P_FETCH, instr, eqv, k == fs);
    end
    r = 1'($urandom_range(0, 1));
    step(r, eqv, 16'($urandom)); cyc++;
    cmp("decode", P_DEC, instr, eqv, r);
    check("ir", ir, instr);
    r = 1'($urandom_range(0, 1));
    step(r, eqv, 16'($urandom)); cyc++;
    cmp("exec", P_EXEC, instr, eqv, r);
    check("onehot", $countones({ADD, NAND, PASS1, EQ}), 1);
    if (retire) ret_cyc = cyc;
    if (memop) begin
      for (int k = 0; k <= ms; k++) begin
        step(k == ms, eqv, 16'($urandom)); cyc++;
        cmp("mem", P_MEM, instr, eqv, k == ms);
        if (retire) ret_cyc = cyc;
      end
    end
    check($sformatf("latency_%h", instr), ret_cyc, memop ? 4 + fs + ms : 3 + fs);
  endtask

  initial begin
    logic [15:0] r;
    rst_n = 1'b0; mem_ready = 1'b1; eq_out = 1'b0; mem_rdata = '0;
    repeat (2) step(1'b1, 1'b0, 16'($urandom));
    check("reset_outputs", 32'(got), 32'd0);
    check("reset_ir", ir, 16'h0000);
    check_perf("reset");
    rst_n = 1'b1;

    run_instr(16'h0503, 0, 0, 1'b0);
    run_instr(16'h73FF, 0, 0, 1'b0);
    run_instr(16'hB77F, 0, 2, 1'b0);
    run_instr(16'hC484, 0, 0, 1'b1);
    run_instr(16'hC484, 1, 0, 1'b0);
    run_instr(16'h2085, 0, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      do r = 16'($urandom); while (r == HALT);
      run_instr(r, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    step(1'b1, 1'b0, 16'h9281); cmp("sw_fetch", P_FETCH, 16'h9281, 1'b0, 1'b1);
    step(1'b0, 1'b0, 16'h0);    cmp("sw_dec",   P_DEC,   16'h9281, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0);    cmp("sw_exec",  P_EXEC,  16'h9281, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0);    cmp("sw_mem",   P_MEM,   16'h9281, 1'b0, 1'b0);
    rst_n = 1'b0;
    step(1'b0, 1'b0, 16'h0);
    check("rstmem_req", mem_req, 1'b0);
    check("rstmem_we", mem_we, 1'b0);
    check("rstmem_wr", {rf_we, pc_we, retire}, 3'b000);
    exp_ret = 0; exp_stall = 0;
    check_perf("rstmem");
    rst_n = 1'b1;

    run_instr(16'h0503, 1, 0, 1'b0);
    run_instr(16'h2085, 0, 0, 1'b0);
    step(1'b1, 1'b0, HALT); cmp("halt_fetch", P_FETCH, HALT, 1'b0, 1'b1);
    step(1'b1, 1'b0, 16'h0); cmp("halt_dec", P_DEC, HALT, 1'b0, 1'b1);
    step(1'b1, 1'b0, 16'h0); cmp("halt_exec", P_EXEC, HALT, 1'b0, 1'b1);
    check("halt_onehot", $countones({ADD, NAND, PASS1, EQ}), 1);
    for (int k = 0; k < 10; k++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
      cmp("halted", P_HALT, HALT, 1'b0, mem_ready);
    end
    check_perf("halt");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running expected done");
    $fatal(1, "timeout");
  end
endmodule
